// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, seven shift/rotate modes,
// single-step shifting and a self-timed burst engine that shifts a
// programmed number of times and pulses Done when finished.
module univ_shift_reg #(
  parameter int BITS  = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [BITS-1:0]  data,
  input  logic             Load,
  input  logic [2:0]       Mode,
  input  logic             In,
  input  logic             Enable,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic [BITS-1:0]  out,
  output logic             SerOutL,
  output logic             SerOutR,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] MODE_SHL  = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_ROL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ASR  = 3'b100;
  localparam logic [2:0] MODE_SHL0 = 3'b101;
  localparam logic [2:0] MODE_SHR0 = 3'b110;

  state_t             state;
  state_t             state_next;
  logic [BITS-1:0]    r;
  logic [BITS-1:0]    r_next;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   rem_next;
  logic [2:0]         lat_mode;
  logic [2:0]         mode_next;
  logic               done_next;

  // One shift step of the register for a given mode; HOLD returns it unchanged
  // so a HOLD burst still burns through its count.
  function automatic logic [BITS-1:0] shift_once(
    input logic [BITS-1:0] v,
    input logic [2:0]      m,
    input logic            s
  );
    logic [BITS-1:0] res;
    case (m)
      MODE_SHL:  res = {v[BITS-2:0], s};
      MODE_SHR:  res = {s, v[BITS-1:1]};
      MODE_ROL:  res = {v[BITS-2:0], v[BITS-1]};
      MODE_ROR:  res = {v[0], v[BITS-1:1]};
      MODE_ASR:  res = {v[BITS-1], v[BITS-1:1]};
      MODE_SHL0: res = {v[BITS-2:0], 1'b0};
      MODE_SHR0: res = {1'b0, v[BITS-1:1]};
      default:   res = v;
    endcase
    return res;
  endfunction

  // State and datapath registers; reset clears everything including a burst in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      r         <= '0;
      remaining <= '0;
      lat_mode  <= 3'b000;
      Done      <= 1'b0;
    end else begin
      state     <= state_next;
      r         <= r_next;
      remaining <= rem_next;
      lat_mode  <= mode_next;
      Done      <= done_next;
    end
  end

  // Next-state logic in priority order: load, burst step, burst accept, single step.
  // Start is only looked at in IDLE, so Start/Enable/Mode/Count are ignored while busy.
  always_comb begin
    state_next = state;
    r_next     = r;
    rem_next   = remaining;
    mode_next  = lat_mode;
    done_next  = 1'b0;
    if (Load) begin
      r_next     = data;
      rem_next   = '0;
      state_next = IDLE;
    end else if (state == RUN) begin
      r_next   = shift_once(r, lat_mode, In);
      rem_next = remaining - 1'b1;
      if (remaining == CNT_W'(1)) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end else if (Start) begin
      mode_next = Mode;
      if (Count == '0) begin
        done_next = 1'b1;
      end else begin
        state_next = RUN;
        rem_next   = Count;
      end
    end else if (Enable) begin
      r_next = shift_once(r, Mode, In);
    end
  end

  // Outputs decoded straight from the registers.
  always_comb begin
    out     = r;
    SerOutL = r[BITS-1];
    SerOutR = r[0];
    Busy    = (state == RUN);
  end

endmodule
